// File: rtl/wwr_ram_sync.sv
// Synchronous write-while-read scratch RAM: one masked write port, one strobed
// registered read port, optional same-address bypass, and a post-reset clear sequencer.
module wwr_ram_sync #(
  parameter int                DATA_W      = 2,
  parameter int                ADDR_W      = 5,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
  parameter int                BYPASS      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_strobe,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic              we,
  output logic              init_busy
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                w_run;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_same_addr;
  logic [DATA_W-1:0]   w_rd_old;
  logic [DATA_W-1:0]   w_wr_merged;
  logic [DATA_W-1:0]   w_rd_next;

  function automatic logic [DATA_W-1:0] merge_word(
    input logic [DATA_W-1:0] new_d,
    input logic [DATA_W-1:0] mask,
    input logic [DATA_W-1:0] old_d
  );
    return (new_d & mask) | (old_d & ~mask);
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == CNT_LAST) w_state_nxt = S_RUN;
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // User ports are only live in RUN and never on a reset edge.
  assign w_run       = (r_state == S_RUN) && !reset;
  assign w_wr_acc    = w_run && ce && we;
  assign w_rd_acc    = w_run && ce && rd_strobe;
  assign w_same_addr = (raddr == waddr);
  assign w_rd_old    = r_mem[raddr];
  assign w_wr_merged = merge_word(wdata, wmask, r_mem[waddr]);
  assign w_rd_next   = ((BYPASS != 0) && w_wr_acc && w_same_addr) ? w_wr_merged : w_rd_old;

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_mem[r_clr_cnt] <= CLEAR_VALUE;
    else if (w_wr_acc)      r_mem[waddr]     <= w_wr_merged;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= w_rd_next;
    end
  end

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign init_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_wwr_ram_sync.sv
// Directed and random bench for wwr_ram_sync: two 32x2 instances (bypass on/off)
// sharing stimulus, plus a 256x16 instance driven by a random stream.
module tb_wwr_ram_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small configuration, shared stimulus
  logic       reset, ce, rd_strobe, we;
  logic [4:0] raddr, waddr;
  logic [1:0] wdata, wmask;
  logic [1:0] rdata1, rdata0;
  logic       rvalid1, rvalid0, busy1, busy0;

  // wide configuration
  logic        g_reset, g_ce, g_rd, g_we;
  logic [7:0]  g_raddr, g_waddr;
  logic [15:0] g_wdata, g_wmask, g_rdata;
  logic        g_rvalid, g_busy;

  wwr_ram_sync #(.DATA_W(2), .ADDR_W(5), .CLEAR_VALUE(2'b10), .BYPASS(1)) u_s1 (
    .clk(clk), .reset(reset), .ce(ce), .raddr(raddr), .rd_strobe(rd_strobe),
    .rdata(rdata1), .rvalid(rvalid1), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .we(we), .init_busy(busy1));

  wwr_ram_sync #(.DATA_W(2), .ADDR_W(5), .CLEAR_VALUE(2'b10), .BYPASS(0)) u_s0 (
    .clk(clk), .reset(reset), .ce(ce), .raddr(raddr), .rd_strobe(rd_strobe),
    .rdata(rdata0), .rvalid(rvalid0), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .we(we), .init_busy(busy0));

  wwr_ram_sync #(.DATA_W(16), .ADDR_W(8), .CLEAR_VALUE(16'h0000), .BYPASS(1)) u_w (
    .clk(clk), .reset(g_reset), .ce(g_ce), .raddr(g_raddr), .rd_strobe(g_rd),
    .rdata(g_rdata), .rvalid(g_rvalid), .waddr(g_waddr), .wdata(g_wdata), .wmask(g_wmask),
    .we(g_we), .init_busy(g_busy));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- small-config reference model and scoreboard
  typedef struct packed {
    logic [1:0] rd1;
    logic [1:0] rd0;
    logic       rv;
    logic       busy;
  } s_exp_t;

  s_exp_t     q_s[$];
  logic [1:0] sm [32];
  int         s_left;
  logic [1:0] s_rd1, s_rd0;
  logic       s_rv;

  task automatic s_step;
    s_exp_t e;
    logic [1:0] old_w, mrg;
    if (reset) begin
      s_left = 32; s_rd1 = 2'b00; s_rd0 = 2'b00; s_rv = 1'b0;
    end else if (s_left > 0) begin
      sm[32 - s_left] = 2'b10;
      s_left--;
      s_rv = 1'b0;
    end else begin
      old_w = sm[raddr];
      mrg   = (wdata & wmask) | (sm[waddr] & ~wmask);
      s_rv  = ce && rd_strobe;
      if (s_rv) begin
        s_rd0 = old_w;
        s_rd1 = (we && (waddr == raddr)) ? mrg : old_w;
      end
      if (ce && we) sm[waddr] = mrg;
    end
    e.rd1 = s_rd1; e.rd0 = s_rd0; e.rv = s_rv; e.busy = (s_left > 0);
    q_s.push_back(e);
    @(posedge clk); #1;
    e = q_s.pop_front();
    check("s1_rdata",  rdata1,  e.rd1);
    check("s0_rdata",  rdata0,  e.rd0);
    check("s1_rvalid", rvalid1, e.rv);
    check("s0_rvalid", rvalid0, e.rv);
    check("s1_busy",   busy1,   e.busy);
    check("s0_busy",   busy0,   e.busy);
  endtask

  task automatic sx(input logic r, input logic c, input logic rd, input logic [4:0] ra,
                    input logic w, input logic [4:0] wa, input logic [1:0] wd, input logic [1:0] wm);
    reset = r; ce = c; rd_strobe = rd; raddr = ra; we = w; waddr = wa; wdata = wd; wmask = wm;
    s_step();
  endtask

  // ---------------- wide-config reference model and scoreboard
  typedef struct packed {
    logic [15:0] rd;
    logic        rv;
    logic        busy;
  } g_exp_t;

  g_exp_t      q_g[$];
  logic [15:0] gm [256];
  int          g_left;
  logic [15:0] g_rd_m;
  logic        g_rv_m;

  task automatic g_step;
    g_exp_t e;
    logic [15:0] old_w, mrg;
    if (g_reset) begin
      g_left = 256; g_rd_m = 16'h0; g_rv_m = 1'b0;
    end else if (g_left > 0) begin
      gm[256 - g_left] = 16'h0;
      g_left--;
      g_rv_m = 1'b0;
    end else begin
      old_w  = gm[g_raddr];
      mrg    = (g_wdata & g_wmask) | (gm[g_waddr] & ~g_wmask);
      g_rv_m = g_ce && g_rd;
      if (g_rv_m) g_rd_m = (g_we && (g_waddr == g_raddr)) ? mrg : old_w;
      if (g_ce && g_we) gm[g_waddr] = mrg;
    end
    e.rd = g_rd_m; e.rv = g_rv_m; e.busy = (g_left > 0);
    q_g.push_back(e);
    @(posedge clk); #1;
    e = q_g.pop_front();
    check("w_rdata",  g_rdata,  e.rd);
    check("w_rvalid", g_rvalid, e.rv);
    check("w_busy",   g_busy,   e.busy);
  endtask

  function automatic logic [7:0] pick_addr();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 8'd0;
    if (sel == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int cnt;
    g_reset = 1'b1; g_ce = 1'b0; g_rd = 1'b0; g_we = 1'b0;
    g_raddr = '0; g_waddr = '0; g_wdata = '0; g_wmask = '0;

    // reset state
    sx(1, 0, 0, 0, 0, 0, 0, 0);
    sx(1, 1, 1, 0, 1, 0, 2'b11, 2'b11);

    // clear sequence length
    cnt = 0;
    do begin sx(0, 0, 0, 0, 0, 0, 0, 0); cnt++; end while (busy1 && cnt < 64);
    check("clear_len", cnt, 32);

    // all addresses read back CLEAR_VALUE, back-to-back
    for (int a = 0; a < 32; a++) sx(0, 1, 1, 5'(a), 0, 0, 0, 0);
    sx(0, 1, 0, 0, 0, 0, 0, 0);

    // masked writes
    sx(0, 1, 0, 0, 1, 5'd7, 2'b11, 2'b11);
    sx(0, 1, 0, 0, 1, 5'd7, 2'b00, 2'b01);
    sx(0, 1, 1, 5'd7, 0, 0, 0, 0);
    check("mask_read7", rdata1, 2'b10);
    sx(0, 1, 0, 0, 1, 5'd7, 2'b01, 2'b00);
    sx(0, 1, 1, 5'd7, 0, 0, 0, 0);
    check("mask0_read7", rdata1, 2'b10);

    // write-while-read on the same address
    sx(0, 1, 0, 0, 1, 5'd3, 2'b01, 2'b11);
    sx(0, 1, 1, 5'd3, 1, 5'd3, 2'b10, 2'b11);
    check("wwr_bypass1", rdata1, 2'b10);
    check("wwr_bypass0", rdata0, 2'b01);
    sx(0, 1, 1, 5'd3, 0, 0, 0, 0);
    check("wwr_next1", rdata1, 2'b10);
    check("wwr_next0", rdata0, 2'b10);

    // strobe hold
    sx(0, 1, 0, 0, 1, 5'd5, 2'b11, 2'b11);
    sx(0, 1, 1, 5'd5, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) sx(0, 1, 0, 5'd5, 1, 5'd5, 2'b00, 2'b11);
    check("hold_rdata", rdata1, 2'b11);
    sx(0, 1, 1, 5'd5, 0, 0, 0, 0);

    // chip enable gating
    sx(0, 0, 1, 5'd9, 1, 5'd9, 2'b01, 2'b11);
    sx(0, 1, 1, 5'd9, 0, 0, 0, 0);
    check("ce_read9", rdata1, 2'b10);

    // reset in the middle of the clear
    sx(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) sx(0, 1, 1, 5'd12, 1, 5'd12, 2'b01, 2'b11);
    sx(1, 1, 1, 5'd12, 1, 5'd12, 2'b01, 2'b11);
    cnt = 0;
    do begin sx(0, 1, 1, 5'd12, 1, 5'd12, 2'b01, 2'b11); cnt++; end while (busy1 && cnt < 64);
    check("reclear_len", cnt, 32);
    sx(0, 1, 1, 5'd12, 0, 0, 0, 0);
    check("drop_read12", rdata1, 2'b10);

    // wide configuration: clear then random stream
    g_step();
    g_reset = 1'b0;
    cnt = 0;
    do begin g_step(); cnt++; end while (g_busy && cnt < 300);
    check("w_clear_len", cnt, 256);
    for (int i = 0; i < 10000; i++) begin
      g_ce    = ($urandom_range(0, 9) != 0);
      g_rd    = $urandom_range(0, 1) == 1;
      g_we    = $urandom_range(0, 1) == 1;
      g_raddr = pick_addr();
      g_waddr = ($urandom_range(0, 3) == 0) ? g_raddr : pick_addr();
      g_wdata = 16'($urandom);
      g_wmask = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      g_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wwr_ram_sync.md
# wwr_ram_sync

Parametrised synchronous write-while-read RAM, the generalised successor to the 32x2 bipolar scratchpad parts in the CADR datapath. It provides one write port with per-bit write mask and one registered read port with a strobe-held output latch. An optional same-cycle write-to-read bypass and a self-clearing sequencer zero the array after reset. It sits wherever the processor needs small dual-address scratch storage, such as the SPC/PDL-style stacks and map memories, and replaces discrete-part models with one synthesizable block.

## Interface
- DATA_W, 2, word width in bits (>=1)
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
- CLEAR_VALUE, 0, DATA_W-bit value written to every word by the clear sequencer
- BYPASS, 1, 1 = read of the address being written returns new data; 0 = returns old data

- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- ce  in  1  chip enable; gates both ports
- raddr  in  ADDR_W  read address
- rd_strobe  in  1  read request; when low, rdata holds
- rdata  out  DATA_W  registered read data
- rvalid  out  1  pulses high the cycle rdata was updated by an accepted read
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wmask  in  DATA_W  per-bit write enable, active-high (generalises WE0/WE1)
- we  in  1  write request
- init_busy  out  1  high while the clear sequencer owns the array

## Operation
- FSM states: CLEAR, RUN.
  - reset=1 -> CLEAR, clear counter = 0.
  - In CLEAR: each cycle write CLEAR_VALUE to mem[counter] and increment the counter.
  - At counter == DEPTH-1, write that word and go to RUN the next cycle.
  - The clear takes exactly DEPTH cycles.
- In CLEAR, user reads and writes are ignored (no array change, rdata holds, rvalid=0), init_busy=1.
- Reset asserted mid-clear, or in RUN, restarts CLEAR at address 0. Prior array contents are not guaranteed until the clear completes.
- Write accepted when: RUN, ce=1, we=1. Then mem[waddr][i] <= wdata[i] for every i with wmask[i]=1; other bits unchanged. wmask=0 means no change.
- Read accepted when: RUN, ce=1, rd_strobe=1. Then:
  - rdata <= mem[raddr] and rvalid <= 1.
  - Otherwise rdata holds its value and rvalid <= 0.
- Write-while-read, same cycle, raddr == waddr, both accepted:
  - BYPASS=1: rdata <= (wdata & wmask) | (old & ~wmask).
  - BYPASS=0: rdata <= old word.
  - In both cases the array holds the merged word afterwards.
- Different addresses: the ports are fully independent.
- Counter width is ADDR_W+1 or a terminal compare at DEPTH-1. There is no wrap back into CLEAR.

## Timing
- Reset values, in the cycle after reset is sampled: rdata=0, rvalid=0, init_busy=1, state=CLEAR.
- Clear completion:
  - init_busy stays high for DEPTH cycles after reset deasserts.
  - It falls on the edge that enters RUN.
  - The first user access is accepted in that first RUN cycle.
- Read latency: 1 cycle. Request at edge N -> rdata/rvalid valid after edge N+1. Back-to-back reads every cycle are supported.
- Write: the array updates at the sampling edge. A read of the same address in the next cycle sees the new data, independent of BYPASS.
- rvalid is a single-cycle pulse per accepted read and never asserts in CLEAR.

## Test plan
- Reset/clear, DATA_W=2, ADDR_W=5, CLEAR_VALUE=2'b10:
  - Release reset -> init_busy high for exactly 32 cycles.
  - Then reads of all 32 addresses return 2'b10, each with rvalid one cycle later.
- Masked write:
  - Write addr 7, wdata=2'b11, wmask=2'b11, then wdata=2'b00, wmask=2'b01 -> read addr 7 returns 2'b10.
  - wmask=2'b00 write -> still 2'b10.
- Write-while-read, mem[3]=2'b01:
  - Same cycle write addr 3 wdata=2'b10 wmask=2'b11 and read addr 3.
  - BYPASS=1 -> rdata=2'b10; BYPASS=0 -> rdata=2'b01.
  - Next-cycle read -> 2'b10 in both.
- Strobe hold and ce gating:
  - Read addr 5 (2'b11), then rd_strobe=0 for 4 cycles while writing addr 5 = 2'b00 -> rdata stays 2'b11, rvalid=0.
  - With ce=0, a write to addr 9 leaves it unchanged.
- Reset mid-clear:
  - Assert reset at clear counter 17 -> sequencer restarts, init_busy high a full 32 cycles after release.
  - Writes attempted during CLEAR are dropped: that address reads CLEAR_VALUE.
- Wide config DATA_W=16, ADDR_W=8: random write/read stream against a reference array model over 10,000 cycles -> zero mismatches, including boundary addresses 0 and 255.
